// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//   Shares one combinational ROM between two read ports. Port 0 is the
//   instruction-fetch path, port 1 the data/constant-read path. At most one
//   request is accepted per cycle. The accepted address drives the ROM, and the
//   returned word is captured into that port's data register, so read data
//   appears one cycle after the grant.
//
// Parameters
//   AWIDTH    ROM address width
//   DWIDTH    ROM data width
//   PRIO_MODE 0: round-robin on contention, 1: port 0 always wins
//
// Ports
//   CLK, RST        rising-edge clock, asynchronous active-high reset
//   REQ0/ADDR0      port 0 request and address (held until granted)
//   GNT0            port 0 accepted this cycle (combinational)
//   VLD0/DATA0      port 0 registered read data and one-cycle valid pulse
//   REQ1/ADDR1,
//   GNT1, VLD1,
//   DATA1           same for port 1
//   ROM_ADDR        address to the ROM (0 when nothing is granted)
//   ROM_DATA        word returned by the ROM for ROM_ADDR
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int AWIDTH    = 4,
    parameter int DWIDTH    = 8,
    parameter bit PRIO_MODE = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic [AWIDTH-1:0] ADDR0,
    output logic              GNT0,
    output logic              VLD0,
    output logic [DWIDTH-1:0] DATA0,
    input  logic              REQ1,
    input  logic [AWIDTH-1:0] ADDR1,
    output logic              GNT1,
    output logic              VLD1,
    output logic [DWIDTH-1:0] DATA1,
    output logic [AWIDTH-1:0] ROM_ADDR,
    input  logic [DWIDTH-1:0] ROM_DATA
);

    // last_q remembers which port won the most recent grant. Resetting it to 1
    // makes port 0 the winner of the first round-robin contention.
    logic              last_q, last_d;
    logic              vld0_q, vld1_q;
    logic [DWIDTH-1:0] data0_q, data0_d;
    logic [DWIDTH-1:0] data1_q, data1_d;
    logic              gnt0, gnt1;

    // Grant decision. Grants are masked while RST is high so that nothing
    // reaches the ROM or the data registers during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            if (REQ0 && REQ1) begin
                if (PRIO_MODE) begin
                    gnt0 = 1'b1;
                end else begin
                    // Round-robin: the port that did not win last time goes.
                    gnt0 = last_q;
                    gnt1 = ~last_q;
                end
            end else begin
                gnt0 = REQ0;
                gnt1 = REQ1;
            end
        end
    end

    // Address mux; the one-hot grant makes priority order here irrelevant.
    always_comb begin
        ROM_ADDR = '0;
        if (gnt0) begin
            ROM_ADDR = ADDR0;
        end else if (gnt1) begin
            ROM_ADDR = ADDR1;
        end
    end

    // Next-state: capture the ROM word for the winner, others hold.
    always_comb begin
        last_d  = last_q;
        data0_d = data0_q;
        data1_d = data1_q;
        if (gnt0) begin
            data0_d = ROM_DATA;
            last_d  = 1'b0;
        end
        if (gnt1) begin
            data1_d = ROM_DATA;
            last_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q  <= 1'b1;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            last_q  <= last_d;
            vld0_q  <= gnt0;   // one-cycle pulse per accepted request
            vld1_q  <= gnt1;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign GNT0  = gnt0;
    assign GNT1  = gnt1;
    assign VLD0  = vld0_q;
    assign VLD1  = vld1_q;
    assign DATA0 = data0_q;
    assign DATA1 = data1_q;

endmodule
